// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {rem, dvd_msb};
  assign q_bit   = (shifted >= {2'b00, divisor});
  // Only consumed when the divisor fits, so the result is known to fit in WIDTH+1 bits.
  assign diff     = shifted[WIDTH:0] - {1'b0, divisor};
  assign rem_next = q_bit ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional DIV_FAST_ZERO_EN: a zero divisor skips the iteration and reports after one cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic             accept;
  logic             load_ops;
  logic             run_step;
  logic             load_out;
  logic             load_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

`ifdef DIV_FAST_ZERO_EN
  // Zero-divisor operation waiting one cycle in IDLE before reporting.
  logic fast_pend;
  logic fast_set;

  assign accept   = start && (state != RUN) && !fast_pend;
  assign fast_set = accept && (divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fast_pend <= 1'b0;
    else        fast_pend <= fast_set;
  end
`else
  assign accept = start && (state != RUN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ops   = 1'b0;
    run_step   = 1'b0;
    load_out   = 1'b0;
    load_zero  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          load_ops   = 1'b1;
          state_next = RUN;
`ifdef DIV_FAST_ZERO_EN
          if (fast_set) state_next = IDLE;
`endif
        end else begin
          state_next = IDLE;
`ifdef DIV_FAST_ZERO_EN
          if (fast_pend) begin
            load_zero  = 1'b1;
            state_next = DONE;
          end
`endif
        end
      end
      RUN: begin
        run_step = 1'b1;
        if (cnt_q == LAST) begin
          load_out   = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load_ops) begin
      rem_q <= '0;
      dvd_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (run_step) begin
      rem_q <= rem_next;
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers only move when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (load_out) begin
      quotient  <= {dvd_q[WIDTH-2:0], q_bit};
      remainder <= rem_next[WIDTH-1:0];
      div_zero  <= (dsr_q == '0);
    end else if (load_zero) begin
      quotient  <= '1;
      remainder <= dvd_q;
      div_zero  <= 1'b1;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start; returns just after the accepting edge (edge k).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the current observation point until done is seen (bounded).
  task automatic wait_done(output int lat, output int bcnt, output int stable);
    logic [W-1:0] q0, r0;
    logic z0;
    q0 = quotient; r0 = remainder; z0 = div_zero;
    lat = 0; bcnt = 0; stable = 1;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (quotient !== q0 || remainder !== r0 || div_zero !== z0) stable = 0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bcnt, stable;
    int eq, er, ez, elat, ebusy;
    if (b == 0) begin
      eq = (1 << W) - 1; er = a; ez = 1;
    end else begin
      eq = a / b; er = a % b; ez = 0;
    end
    elat  = (FAST && b == 0) ? 1 : W;
    ebusy = (FAST && b == 0) ? 0 : W;
    start_op(a, b);
    wait_done(lat, bcnt, stable);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".busy_cycles"}, bcnt, ebusy);
    check({tag, ".held"}, stable, 1);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_zero"}, div_zero, ez);
    @(posedge clk);
    #1;
    check({tag, ".done_falls"}, done, 0);
  endtask

  initial begin
    int lat, bcnt, stable, d0;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #3;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_check("d200_7", 200, 7);
    run_check("d255_1", 255, 1);
    run_check("d5_9", 5, 9);
    run_check("d100_0", 100, 0);
    run_check("d0_5", 0, 5);
    run_check("d255_255", 255, 255);

    // start during RUN must be ignored
    start_op(200, 7);
    d0 = done_cnt;
    @(negedge clk); @(negedge clk);
    start = 1'b1; dividend = 50; divisor = 3;
    @(negedge clk);
    start = 1'b0; dividend = 0; divisor = 0;
    wait_done(lat, bcnt, stable);
    check("ign.quotient", quotient, 28);
    check("ign.remainder", remainder, 4);
    repeat (12) @(posedge clk);
    #1;
    check("ign.done_pulses", done_cnt - d0, 1);
    check("ign.busy_after", busy, 0);

    // back-to-back start in the DONE cycle
    start_op(200, 7);
    wait_done(lat, bcnt, stable);
    check("b2b.first_latency", lat, W);
    check("b2b.first_quotient", quotient, 28);
    start_op(17, 4);
    check("b2b.busy_restart", busy, 1);
    check("b2b.done_drops", done, 0);
    check("b2b.held_quotient", quotient, 28);
    wait_done(lat, bcnt, stable);
    check("b2b.second_latency", lat, W);
    check("b2b.second_quotient", quotient, 4);
    check("b2b.second_remainder", remainder, 1);

    // reset in the middle of an operation
    @(negedge clk);
    start_op(200, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.quotient", quotient, 0);
    check("abort.remainder", remainder, 0);
    check("abort.div_zero", div_zero, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort.no_done", done_cnt - d0, 0);
    check("abort.idle", busy, 0);
    run_check("d9_2", 9, 2);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      run_check($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
